// File: rtl/dcache_load_ctrl_pkg.sv
// Shared definitions for the load-side data cache: bus/size encodings,
// default cache geometry, the line layout and the load extraction helper.
package dcache_load_ctrl_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } MEM_SIZE;

    typedef enum logic [1:0] {
        BUS_NONE = 2'd0,
        BUS_LOAD = 2'd1
    } BUS_COMMAND;

    localparam int unsigned CACHE_LINES = 32;
    localparam int unsigned IDX_BITS    = $clog2(CACHE_LINES);
    localparam int unsigned TAG_BITS    = 29 - IDX_BITS;

    typedef struct packed {
        logic                valid;
        logic [TAG_BITS-1:0] tag;
        logic [63:0]         data;
    } DCACHE_LINE;

    // size[2] set means unsigned; WORD has nothing to extend so it ignores it.
    function automatic logic [31:0] load_extract(input logic [63:0] blk,
                                                 input logic [2:0]  off,
                                                 input logic [2:0]  size);
        logic [31:0] r;
        logic [7:0]  b;
        logic [15:0] h;
        r = '0;
        case (size[1:0])
            BYTE: begin
                b = blk[{off, 3'b000} +: 8];
                r = {{24{b[7] & ~size[2]}}, b};
            end
            HALF: begin
                h = blk[{off[2:1], 4'b0000} +: 16];
                r = {{16{h[15] & ~size[2]}}, h};
            end
            default: r = blk[{off[2], 5'b00000} +: 32];
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dcache_mem.sv
// Direct-mapped tag/data/valid arrays: two asynchronous read ports (lookup,
// snoop), one synchronous fill port and a separate invalidate port.
module dcache_mem import dcache_load_ctrl_pkg::*; #(
    parameter int unsigned CACHE_LINES = dcache_load_ctrl_pkg::CACHE_LINES,
    localparam int unsigned IDX_W = $clog2(CACHE_LINES),
    localparam int unsigned TAG_W = 29 - IDX_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [63:0]      rd_data,
    input  logic [IDX_W-1:0] sn_idx,
    output logic             sn_valid,
    output logic [TAG_W-1:0] sn_tag,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [63:0]      wr_data,
    input  logic             wr_set_valid,
    input  logic             inv_en,
    input  logic [IDX_W-1:0] inv_idx
);

    logic [CACHE_LINES-1:0] valid_q;
    logic [TAG_W-1:0]       tags_q [CACHE_LINES];
    logic [63:0]            data_q [CACHE_LINES];

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tags_q[rd_idx];
    assign rd_data  = data_q[rd_idx];
    assign sn_valid = valid_q[sn_idx];
    assign sn_tag   = tags_q[sn_idx];

    // Fill is applied after invalidate so a fill of a different block into a
    // line being snooped away still ends up valid.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            if (inv_en) valid_q[inv_idx] <= 1'b0;
            if (wr_en)  valid_q[wr_idx]  <= wr_set_valid;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            tags_q[wr_idx] <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/dcache_load_ctrl.sv
// Blocking load-side cache controller: zero-latency hits, single outstanding
// miss with fill-and-forward, and store-commit snoop invalidation.
module dcache_load_ctrl import dcache_load_ctrl_pkg::*; #(
    parameter int unsigned CACHE_LINES = dcache_load_ctrl_pkg::CACHE_LINES
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rd_cache,
    input  logic [31:0] addr,
    input  logic [2:0]  mem_size,
    input  logic        st_valid,
    input  logic [31:0] st_addr,
    output logic        cache_valid,
    output logic [31:0] cache_data,
    output logic [1:0]  mem_command,
    output logic [31:0] mem_addr,
    input  logic [3:0]  mem_response,
    input  logic [63:0] mem_data,
    input  logic [3:0]  mem_tag
);

    localparam int unsigned IDX_W = $clog2(CACHE_LINES);
    localparam int unsigned TAG_W = 29 - IDX_W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [2:0]  req_size_q, req_size_d;
    logic [3:0]  tag_q, tag_d;

    logic             rd_valid, sn_valid, fill_en, fill_set_valid, inv_en, hit;
    logic [TAG_W-1:0] rd_tag, sn_tag;
    logic [63:0]      rd_data;
    logic             unused_st_offset;

    assign unused_st_offset = ^st_addr[2:0];

    dcache_mem #(.CACHE_LINES(CACHE_LINES)) u_mem (
        .clock        (clock),
        .reset        (reset),
        .rd_idx       (addr[3 +: IDX_W]),
        .rd_valid     (rd_valid),
        .rd_tag       (rd_tag),
        .rd_data      (rd_data),
        .sn_idx       (st_addr[3 +: IDX_W]),
        .sn_valid     (sn_valid),
        .sn_tag       (sn_tag),
        .wr_en        (fill_en),
        .wr_idx       (req_addr_q[3 +: IDX_W]),
        .wr_tag       (req_addr_q[31 -: TAG_W]),
        .wr_data      (mem_data),
        .wr_set_valid (fill_set_valid),
        .inv_en       (inv_en),
        .inv_idx      (st_addr[3 +: IDX_W])
    );

    assign hit    = rd_valid && (rd_tag == addr[31 -: TAG_W]);
    assign inv_en = st_valid && sn_valid && (sn_tag == st_addr[31 -: TAG_W]);
    // A same-block store during the fill cycle means the returning data is stale.
    assign fill_set_valid = !(st_valid && (st_addr[31:3] == req_addr_q[31:3]));

    always_comb begin
        state_d     = state_q;
        req_addr_d  = req_addr_q;
        req_size_d  = req_size_q;
        tag_d       = tag_q;
        fill_en     = 1'b0;
        cache_valid = 1'b0;
        cache_data  = '0;
        mem_command = BUS_NONE;
        mem_addr    = '0;
        case (state_q)
            S_IDLE: begin
                if (rd_cache) begin
                    if (hit) begin
                        cache_valid = 1'b1;
                        cache_data  = load_extract(rd_data, addr[2:0], mem_size);
                    end else begin
                        req_addr_d = addr;
                        req_size_d = mem_size;
                        state_d    = S_REQ;
                    end
                end
            end
            S_REQ: begin
                mem_command = BUS_LOAD;
                mem_addr    = {req_addr_q[31:3], 3'b000};
                if (mem_response != 4'd0) begin
                    tag_d   = mem_response;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if ((mem_tag != 4'd0) && (mem_tag == tag_q)) begin
                    fill_en     = 1'b1;
                    cache_valid = 1'b1;
                    cache_data  = load_extract(mem_data, req_addr_q[2:0], req_size_q);
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            req_addr_q <= '0;
            req_size_q <= '0;
            tag_q      <= '0;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            req_size_q <= req_size_d;
            tag_q      <= tag_d;
        end
    end

endmodule

// File: tb/tb_dcache_load_ctrl.sv
// Directed bench for dcache_load_ctrl: misses, extraction, back-to-back hits,
// snoop invalidation, backpressure and reset during an outstanding miss.
module tb_dcache_load_ctrl;

    logic        clock;
    logic        reset;
    logic        rd_cache;
    logic [31:0] addr;
    logic [2:0]  mem_size;
    logic        st_valid;
    logic [31:0] st_addr;
    logic        cache_valid;
    logic [31:0] cache_data;
    logic [1:0]  mem_command;
    logic [31:0] mem_addr;
    logic [3:0]  mem_response;
    logic [63:0] mem_data;
    logic [3:0]  mem_tag;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    dcache_load_ctrl #(.CACHE_LINES(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .rd_cache     (rd_cache),
        .addr         (addr),
        .mem_size     (mem_size),
        .st_valid     (st_valid),
        .st_addr      (st_addr),
        .cache_valid  (cache_valid),
        .cache_data   (cache_data),
        .mem_command  (mem_command),
        .mem_addr     (mem_addr),
        .mem_response (mem_response),
        .mem_data     (mem_data),
        .mem_tag      (mem_tag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_hit(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] exp);
        addr     = a;
        mem_size = sz;
        rd_cache = 1'b1;
        @(negedge clock);
        check("hit_valid", cache_valid, 1'b1);
        check("hit_data", cache_data, exp);
        check("hit_no_cmd", mem_command, 2'd0);
        tick();
    endtask

    task automatic do_miss(input logic [31:0] a, input logic [2:0] sz, input logic [3:0] t,
                           input logic [63:0] d, input logic [31:0] exp,
                           input int unsigned stall, input bit snoop_fill);
        addr     = a;
        mem_size = sz;
        rd_cache = 1'b1;
        @(negedge clock);
        check("miss_no_valid", cache_valid, 1'b0);
        check("miss_idle_cmd", mem_command, 2'd0);
        tick();
        for (int unsigned i = 0; i < stall; i++) begin
            @(negedge clock);
            check("stall_cmd", mem_command, 2'd1);
            check("stall_addr", mem_addr, {a[31:3], 3'b000});
            check("stall_no_valid", cache_valid, 1'b0);
            tick();
        end
        mem_response = t;
        @(negedge clock);
        check("req_cmd", mem_command, 2'd1);
        check("req_addr", mem_addr, {a[31:3], 3'b000});
        tick();
        mem_response = 4'd0;
        @(negedge clock);
        check("wait_cmd", mem_command, 2'd0);
        check("wait_addr", mem_addr, 32'd0);
        check("wait_no_valid", cache_valid, 1'b0);
        tick();
        mem_tag  = t;
        mem_data = d;
        if (snoop_fill) begin
            st_valid = 1'b1;
            st_addr  = {a[31:3], 3'b100};
        end
        @(negedge clock);
        check("fill_valid", cache_valid, 1'b1);
        check("fill_data", cache_data, exp);
        tick();
        mem_tag  = 4'd0;
        mem_data = '0;
        st_valid = 1'b0;
        rd_cache = 1'b0;
    endtask

    initial begin
        reset = 1'b1; rd_cache = 1'b0; addr = '0; mem_size = '0;
        st_valid = 1'b0; st_addr = '0; mem_response = '0; mem_data = '0; mem_tag = '0;
        tick(); tick();
        @(negedge clock);
        check("rst_valid", cache_valid, 1'b0);
        check("rst_data", cache_data, 32'd0);
        check("rst_cmd", mem_command, 2'd0);
        check("rst_addr", mem_addr, 32'd0);
        reset = 1'b0;
        tick();

        // Cold miss, then a zero-latency repeat hit
        do_miss(32'h100, 3'd2, 4'd3, 64'h0000_0000_DEAD_BEEF, 32'hDEAD_BEEF, 0, 1'b0);
        do_hit(32'h100, 3'd2, 32'hDEAD_BEEF);
        rd_cache = 1'b0;

        // Sign/zero extension on line 0x108
        do_miss(32'h108, 3'd2, 4'd4, 64'h80FF_0000_0000_0000, 32'h0000_0000, 0, 1'b0);
        do_hit(32'h10F, 3'd0, 32'hFFFF_FF80);
        do_hit(32'h10F, 3'd4, 32'h0000_0080);
        do_hit(32'h10E, 3'd1, 32'hFFFF_80FF);
        do_hit(32'h10F, 3'd2, 32'h80FF_0000);
        rd_cache = 1'b0;

        // Back-to-back hits: a pulse in every consecutive cycle
        do_hit(32'h100, 3'd2, 32'hDEAD_BEEF);
        do_hit(32'h10F, 3'd0, 32'hFFFF_FF80);
        do_hit(32'h10E, 3'd5, 32'h0000_80FF);
        do_hit(32'h104, 3'd2, 32'h0000_0000);
        rd_cache = 1'b0;

        // Store to a different tag at the same index leaves the line alone
        st_valid = 1'b1; st_addr = 32'h2108;
        tick();
        st_valid = 1'b0;
        do_hit(32'h10F, 3'd0, 32'hFFFF_FF80);
        rd_cache = 1'b0;

        // Matching snoop invalidates; refill with 5 cycles of backpressure
        st_valid = 1'b1; st_addr = 32'h104;
        tick();
        st_valid = 1'b0;
        do_miss(32'h100, 3'd2, 4'd6, 64'h1122_3344_5566_7788, 32'h5566_7788, 5, 1'b0);
        do_hit(32'h104, 3'd2, 32'h1122_3344);
        rd_cache = 1'b0;

        // Fill coinciding with a same-block snoop: delivered but not cached
        do_miss(32'h200, 3'd2, 4'd7, 64'hAAAA_BBBB_CCCC_DDDD, 32'hCCCC_DDDD, 0, 1'b1);
        do_miss(32'h200, 3'd1, 4'd8, 64'h0123_4567_89AB_CDEF, 32'hFFFF_CDEF, 1, 1'b0);

        // Hit and snoop to the same line in one cycle: old data, then a miss
        st_valid = 1'b1; st_addr = 32'h200;
        do_hit(32'h202, 3'd5, 32'h0000_89AB);
        st_valid = 1'b0;
        rd_cache = 1'b0;
        do_miss(32'h200, 3'd2, 4'd9, 64'h0000_0000_1357_9BDF, 32'h1357_9BDF, 0, 1'b0);

        // Reset while waiting on tag 5; the late tag must be ignored
        addr = 32'h300; mem_size = 3'd2; rd_cache = 1'b1;
        tick();
        mem_response = 4'd5;
        tick();
        mem_response = 4'd0;
        reset = 1'b1;
        rd_cache = 1'b0;
        tick();
        reset = 1'b0;
        mem_tag = 4'd5; mem_data = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clock);
        check("rst_wait_no_valid", cache_valid, 1'b0);
        check("rst_wait_data", cache_data, 32'd0);
        check("rst_wait_cmd", mem_command, 2'd0);
        tick();
        mem_tag = 4'd0; mem_data = '0;
        @(negedge clock);
        check("rst_late_no_valid", cache_valid, 1'b0);
        tick();
        addr = 32'h100; mem_size = 3'd2; rd_cache = 1'b1;
        @(negedge clock);
        check("rst_line_invalid", cache_valid, 1'b0);
        tick();
        @(negedge clock);
        check("rst_idle_accept_cmd", mem_command, 2'd1);
        check("rst_idle_accept_addr", mem_addr, 32'h100);
        rd_cache = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dcache_load_ctrl.md
# dcache_load_ctrl

Blocking load-side data-cache controller that feeds the load buffer. It takes one read request at a time (rd_cache/addr/mem_size), looks it up in a direct-mapped cache, and fetches the 8-byte block from memory on a miss. It returns the size-extracted, sign/zero-extended value as a one-cycle cache_valid/cache_data pulse. Store commits snoop the tag array so stale lines are invalidated.

## Interface
- CACHE_LINES, 32, number of direct-mapped lines, power of two; index = addr[3+:log2(CACHE_LINES)], tag = remaining upper bits.
- clock  in  1  clock; all state updates on posedge.
- reset  in  1  reset, synchronous, active-high.
- rd_cache  in  1  load request valid; held until the response pulse.
- addr  in  32  load byte address.
- mem_size  in  3  [1:0] BYTE=0/HALF=1/WORD=2; [2]=1 means unsigned.
- st_valid  in  1  committed store snoop valid.
- st_addr  in  32  committed store byte address.
- cache_valid  out  1  response pulse, exactly one cycle per request.
- cache_data  out  32  extracted and extended load value; 0 when cache_valid=0.
- mem_command  out  2  BUS_NONE=0, BUS_LOAD=1.
- mem_addr  out  32  block address {addr[31:3],3'b0} during a fill request; 0 otherwise.
- mem_response  in  4  nonzero tag means the memory accepted the command this cycle.
- mem_data  in  64  fill data.
- mem_tag  in  4  tag of the returning data; 0 means none.

## Operation
- FSM states: IDLE, REQ, WAIT.
- IDLE
  - rd_cache with a hit: cache_valid=1 in the same cycle (combinational from the arrays); stay in IDLE.
  - rd_cache with a miss: latch addr and mem_size; go to REQ.
- REQ
  - Drive mem_command=BUS_LOAD and mem_addr every cycle.
  - On mem_response!=0: latch the tag, go to WAIT.
  - On mem_response=0: stay in REQ and keep driving the command.
- WAIT
  - Command outputs are idle.
  - On mem_tag==latched tag (and nonzero): write the line data, tag and valid bit; assert cache_valid with data extracted from mem_data (fill-and-forward); go to IDLE.
- Extraction: byte offset = addr[2:0].
  - BYTE: selects 8 bits; HALF ignores addr[0]; WORD ignores addr[1:0]. Misaligned low bits are silently cleared.
  - Signed sizes sign-extend to 32 bits; unsigned sizes zero-extend. WORD ignores bit 2.
- Snoop: st_valid with a tag match at the st_addr index clears that valid bit next edge. Non-matching tags leave the line untouched.
- Fill and snoop to the same block in the same cycle: the response is still delivered, but the line is not marked valid.
- Snoop and hit to the same line in the same cycle: the hit is served from the old contents; the invalidate takes effect next edge.
- rd_cache deasserting mid-miss is illegal (requests are held). The fill still completes and its response is dropped only by reset.

## Timing
- Reset values:
  - FSM=IDLE, all valid bits 0, latched tag 0.
  - cache_valid=0, cache_data=0, mem_command=BUS_NONE, mem_addr=0.
- Hit latency: 0 cycles. Back-to-back hits give one response per cycle, because the load buffer advances its pointer on cache_valid.
- Miss latency: 1 (IDLE→REQ) + cycles until mem_response + cycles until the tag returns. The response occurs in the tag-match cycle.
- No new request is accepted in REQ or WAIT.
- Reset mid-miss: return to IDLE and abandon the outstanding tag. A later mem_tag equal to the old tag is ignored because the FSM is in IDLE.
- Cycles with mem_tag match but not in WAIT are ignored.

## Structure
- Shared package (sys_defs):
  - MEM_SIZE enum.
  - BUS_COMMAND enum.
  - DCACHE_LINE struct {valid, tag, data[63:0]}.
  - CACHE_LINES define.
- One sub-module, dcache_mem:
  - Arrays of valid, tag and data.
  - Asynchronous read port for lookup and a second asynchronous read port for snoop.
  - One synchronous write port for fill and a separate invalidate port.
- dcache_load_ctrl holds the FSM, the latched request and the extraction logic.

## Test plan
- Cold miss: LW at 0x100 with mem_size=2. Expect mem_command=LOAD, mem_addr=0x100. Memory returns response=3, then tag=3 with data 0x0000_0000_DEAD_BEEF. Expect one cache_valid pulse with 0xDEADBEEF; a repeat LW at 0x100 then hits in 0 cycles.
- Extension: line 0x108 holds 0x80FF_0000_0000_0000.
  - LB at 0x10F: 0xFFFFFF80.
  - LBU at 0x10F: 0x00000080.
  - LH at 0x10E: 0xFFFF80FF.
- Back-to-back: 4 hits in consecutive cycles give 4 pulses in consecutive cycles with no idle gap.
- Snoop: store to 0x104 after the line is filled, then LW at 0x100. Expect a miss and a new BUS_LOAD to 0x100. A fill coinciding with a same-block snoop still delivers data, and the next access misses.
- Backpressure: mem_response=0 for 5 cycles. Expect mem_command to hold LOAD at the same mem_addr throughout, and no cache_valid.
- Reset in WAIT with tag 5, then mem_tag=5 after reset. Expect no cache_valid, all lines invalid, and the FSM in IDLE.
